// File: rtl/tile_cfg_pkg.sv
// Shared definitions for the tile configuration path: word geometry and
// the loader state encoding. Imported by the loader, the Tile bench and
// any array top.
package tile_cfg_pkg;

   // Width of one tile configuration word (Tile `bits` port)
   localparam int CFG_W = 77;

   // Number of stream bytes needed to carry a word of width w
   function automatic int bytes_for(input int w);
      return (w + 7) / 8;
   endfunction

   // Data bytes per frame for the default word width
   localparam int BYTES_PER_CFG = bytes_for(CFG_W);

   // Loader frame states
   typedef enum logic [1:0] {
      S_ADDR   = 2'd0,
      S_DATA   = 2'd1,
      S_COMMIT = 2'd2,
      S_DROP   = 2'd3
   } cfg_state_t;

endpackage

// File: rtl/tile_cfg_loader_assembler.sv
// Byte assembler for tile configuration words. Bytes arrive least
// significant first. Only the first N-1 bytes are stored. The final byte
// is merged combinationally into `word`, so the loader can register the
// complete word on the same edge that accepts the last byte. Upper bits
// of the final byte that fall beyond CFG_W are dropped.
module cfg_byte_assembler
   import tile_cfg_pkg::*;
#(
   parameter int CFG_W = tile_cfg_pkg::CFG_W
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clr,
   input  logic             shift,
   input  logic [7:0]       data,
   output logic [CFG_W-1:0] word
);

   localparam int NB    = bytes_for(CFG_W);
   localparam int SR_W  = 8 * (NB - 1);
   localparam int TOP_W = CFG_W - SR_W;

   logic [SR_W-1:0] sr_r;

   // Shift register: each new byte enters at the top, so after NB-1 shifts
   // byte 0 sits at [7:0]. Clear wins over shift.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sr_r <= '0;
      end else if (clr) begin
         sr_r <= '0;
      end else if (shift) begin
         sr_r <= {data, sr_r[SR_W-1:8]};
      end else begin
         sr_r <= sr_r;
      end
   end

   // The word as it stands once the byte on `data` is appended. The final
   // byte is truncated to the bits that fit in CFG_W.
   assign word = {data[TOP_W-1:0], sr_r};

endmodule

// File: rtl/tile_cfg_loader.sv
// Configuration sequencer for the tile array. It parses
// address + data-byte frames from the host stream and commits each
// assembled word to one tile with a single-cycle one-hot write strobe on
// the shared config bus. It tracks which tiles have been written.
module tile_cfg_loader
   import tile_cfg_pkg::*;
#(
   parameter int NUM_TILES = 16,
   parameter int CFG_W     = tile_cfg_pkg::CFG_W
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [7:0]           in_data,
   input  logic                 in_valid,
   output logic                 in_ready,
   output logic [NUM_TILES-1:0] wr_en,
   output logic [CFG_W-1:0]     bits,
   output logic                 busy,
   output logic                 err,
   output logic                 all_cfg
);

   localparam int                NB     = bytes_for(CFG_W);
   localparam int                CNT_W  = $clog2(NB);
   localparam logic [CNT_W-1:0]  LAST_C = CNT_W'(NB - 1);
   localparam logic [8:0]        NT_V   = 9'(NUM_TILES);

   cfg_state_t           state_r, state_nxt_s;
   logic [CNT_W-1:0]     cnt_r, cnt_nxt_s;
   logic [7:0]           addr_r, addr_nxt_s;
   logic                 xfer_s;
   logic                 clr_s;
   logic                 shift_s;
   logic                 err_set_s;
   logic [CFG_W-1:0]     word_s;
   logic [NUM_TILES-1:0] wr_nxt_s;
   logic                 commit_nxt_s;

   logic                 in_ready_r;
   logic                 busy_r;
   logic                 err_r;
   logic                 all_cfg_r;
   logic [NUM_TILES-1:0] wr_en_r;
   logic [NUM_TILES-1:0] written_r;
   logic [CFG_W-1:0]     bits_r;

   // A byte moves only when the registered ready and the host valid agree
   assign xfer_s = in_valid & in_ready_r;

   cfg_byte_assembler #(
      .CFG_W (CFG_W)
   ) u_asm (
      .clk   (clk),
      .reset (reset),
      .clr   (clr_s),
      .shift (shift_s),
      .data  (in_data),
      .word  (word_s)
   );

   // FSM state, byte counter and latched address
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r <= S_ADDR;
         cnt_r   <= '0;
         addr_r  <= 8'd0;
      end else begin
         state_r <= state_nxt_s;
         cnt_r   <= cnt_nxt_s;
         addr_r  <= addr_nxt_s;
      end
   end

   // Frame sequencing: address decode, data count, commit and drop paths
   always_comb begin
      state_nxt_s = state_r;
      cnt_nxt_s   = cnt_r;
      addr_nxt_s  = addr_r;
      clr_s       = 1'b0;
      shift_s     = 1'b0;
      err_set_s   = 1'b0;
      case (state_r)
         S_ADDR: begin
            if (xfer_s) begin
               addr_nxt_s = in_data;
               cnt_nxt_s  = '0;
               clr_s      = 1'b1;
               if ({1'b0, in_data} < NT_V) begin
                  state_nxt_s = S_DATA;
               end else begin
                  err_set_s   = 1'b1;
                  state_nxt_s = S_DROP;
               end
            end else begin
               state_nxt_s = S_ADDR;
            end
         end
         S_DATA: begin
            if (xfer_s) begin
               shift_s = 1'b1;
               if (cnt_r == LAST_C) begin
                  cnt_nxt_s   = '0;
                  state_nxt_s = S_COMMIT;
               end else begin
                  cnt_nxt_s = cnt_r + CNT_W'(1);
               end
            end else begin
               state_nxt_s = S_DATA;
            end
         end
         S_COMMIT: begin
            state_nxt_s = S_ADDR;
         end
         S_DROP: begin
            if (xfer_s) begin
               if (cnt_r == LAST_C) begin
                  cnt_nxt_s   = '0;
                  state_nxt_s = S_ADDR;
               end else begin
                  cnt_nxt_s = cnt_r + CNT_W'(1);
               end
            end else begin
               state_nxt_s = S_DROP;
            end
         end
         default: begin
            state_nxt_s = S_ADDR;
            cnt_nxt_s   = '0;
         end
      endcase
   end

   // One-hot strobe for the cycle in which the FSM will sit in S_COMMIT
   always_comb begin
      commit_nxt_s = (state_nxt_s == S_COMMIT);
      wr_nxt_s     = '0;
      for (int i = 0; i < NUM_TILES; i++) begin
         if (commit_nxt_s && (addr_r == 8'(i))) begin
            wr_nxt_s[i] = 1'b1;
         end else begin
            wr_nxt_s[i] = 1'b0;
         end
      end
   end

   // Registered handshake and status outputs, derived from the next state
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         in_ready_r <= 1'b0;
         busy_r     <= 1'b0;
         err_r      <= 1'b0;
      end else begin
         in_ready_r <= (state_nxt_s != S_COMMIT);
         busy_r     <= (state_nxt_s != S_ADDR);
         err_r      <= err_r | err_set_s;
      end
   end

   // Commit bus: the word is driven only alongside its strobe and is zero otherwise
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_en_r <= '0;
         bits_r  <= '0;
      end else begin
         wr_en_r <= wr_nxt_s;
         bits_r  <= commit_nxt_s ? word_s : '0;
      end
   end

   // Written mask and done flag. Both take the live strobe into account, so
   // all_cfg rises in the cycle right after the completing commit.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         written_r <= '0;
         all_cfg_r <= 1'b0;
      end else begin
         written_r <= written_r | wr_en_r;
         all_cfg_r <= &(written_r | wr_en_r);
      end
   end

   assign in_ready = in_ready_r;
   assign busy     = busy_r;
   assign err      = err_r;
   assign all_cfg  = all_cfg_r;
   assign wr_en    = wr_en_r;
   assign bits     = bits_r;

endmodule

// File: tb/tb_tile_cfg_loader.sv
// Self-checking bench for tile_cfg_loader with NUM_TILES=4: a table of
// frames plus hand-written sequences for all_cfg timing and reset mid-frame.
// Expected commits are queued when a frame starts and are checked by a
// negedge monitor.
module tb_tile_cfg_loader;

   localparam int NT = 4;

   logic          clk;
   logic          reset;
   logic [7:0]    in_data;
   logic          in_valid;
   logic          in_ready;
   logic [NT-1:0] wr_en;
   logic [76:0]   bits;
   logic          busy;
   logic          err;
   logic          all_cfg;

   tile_cfg_loader #(
      .NUM_TILES (NT),
      .CFG_W     (77)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .in_data  (in_data),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .wr_en    (wr_en),
      .bits     (bits),
      .busy     (busy),
      .err      (err),
      .all_cfg  (all_cfg)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic [NT-1:0] wr;
      logic [76:0]   bits;
   } sb_t;

   typedef struct {
      logic [7:0]    addr;
      logic [79:0]   data;
      bit            gaps;
      logic [NT-1:0] exp_wr;
      logic          exp_err;
   } vec_t;

   sb_t  sb_q[$];
   sb_t  mon_e;
   vec_t vecs[7];
   int   n_checks = 0;
   int   n_fail   = 0;
   int   pulses   = 0;
   int   pushes   = 0;
   bit   mon_en   = 1'b0;
   bit   chk_en   = 1'b0;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Commit monitor: pops the scoreboard on every strobe and polices the idle bus
   always @(negedge clk) begin
      if (mon_en) begin
         if (wr_en !== 4'd0) begin
            pulses++;
            if (sb_q.size() == 0) begin
               chk("unexpected_wr_en", {124'd0, wr_en}, 128'd0);
            end else begin
               mon_e = sb_q.pop_front();
               chk("commit_wr_en", {124'd0, wr_en}, {124'd0, mon_e.wr});
               chk("commit_bits", {51'd0, bits}, {51'd0, mon_e.bits});
            end
         end else begin
            chk("bits_idle_zero", {51'd0, bits}, 128'd0);
         end
         if (chk_en && !reset) begin
            chk("in_ready_low_only_in_commit", {127'd0, in_ready}, {127'd0, (wr_en == 4'd0)});
         end
      end
   end

   task automatic send_byte(input logic [7:0] b, input bit gaps);
      int n;
      if (gaps && ($urandom_range(0, 1) == 1)) begin
         in_valid = 1'b0;
         @(negedge clk);
      end
      in_valid = 1'b1;
      in_data  = b;
      n = 0;
      while (!in_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("ready_wait", {127'd0, in_ready}, 128'd1);
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic send_frame(input logic [7:0] a, input logic [79:0] d, input bit gaps,
                             input logic [NT-1:0] w);
      sb_t         e;
      logic [79:0] dd;
      if (w != 4'd0) begin
         dd     = d;
         e.wr   = w;
         e.bits = dd[76:0];
         sb_q.push_back(e);
         pushes++;
      end
      send_byte(a, gaps);
      for (int k = 0; k < 10; k++) begin
         send_byte(d[8*k +: 8], gaps);
      end
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while (busy && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("idle_reached", {127'd0, busy}, 128'd0);
      @(negedge clk);
   endtask

   task automatic reset_dut();
      @(negedge clk);
      chk_en   = 1'b0;
      reset    = 1'b1;
      in_valid = 1'b0;
      @(negedge clk);
      chk("rst_wr_en", {124'd0, wr_en}, 128'd0);
      chk("rst_bits", {51'd0, bits}, 128'd0);
      chk("rst_in_ready", {127'd0, in_ready}, 128'd0);
      chk("rst_busy", {127'd0, busy}, 128'd0);
      chk("rst_err", {127'd0, err}, 128'd0);
      chk("rst_all_cfg", {127'd0, all_cfg}, 128'd0);
      reset = 1'b0;
      @(negedge clk);
      chk("ready_after_reset", {127'd0, in_ready}, 128'd1);
      chk_en = 1'b1;
   endtask

   initial begin
      logic [79:0]   rd;
      logic [3:0]    order[5];
      int            base;
      reset    = 1'b1;
      in_valid = 1'b0;
      in_data  = 8'd0;
      @(negedge clk);
      mon_en = 1'b1;
      reset_dut();

      // Table: addr, data (byte k at [8k+7:8k]), gaps, expected strobe, err afterwards
      vecs[0] = '{8'h02, 80'h1F_00_00_00_00_00_00_00_00_FF, 1'b0, 4'b0100, 1'b0};
      vecs[1] = '{8'h07, 80'h01_23_45_67_89_AB_CD_EF_13_57, 1'b0, 4'b0000, 1'b1};
      vecs[2] = '{8'h01, 80'h1F_00_00_00_00_00_00_00_00_FF, 1'b1, 4'b0010, 1'b1};
      vecs[3] = '{8'h03, 80'hE0_A5_5A_C3_3C_96_69_0F_F0_81, 1'b1, 4'b1000, 1'b1};
      vecs[4] = '{8'h04, 80'hFF_EE_DD_CC_BB_AA_99_88_77_66, 1'b1, 4'b0000, 1'b1};
      vecs[5] = '{8'h00, 80'hFF_FF_FF_FF_FF_FF_FF_FF_FF_FF, 1'b0, 4'b0001, 1'b1};
      vecs[6] = '{8'h01, 80'h15_2A_3B_4C_5D_6E_7F_80_91_A2, 1'b1, 4'b0010, 1'b1};

      for (int i = 0; i < 7; i++) begin
         send_frame(vecs[i].addr, vecs[i].data, vecs[i].gaps, vecs[i].exp_wr);
         wait_idle();
         chk("err_after_frame", {127'd0, err}, {127'd0, vecs[i].exp_err});
      end
      chk("table_all_cfg", {127'd0, all_cfg}, 128'd1);
      chk("table_sb_drained", 128'(sb_q.size()), 128'd0);

      // all_cfg timing: tiles 3,1,0,1,2 after a fresh reset
      reset_dut();
      order = '{4'd3, 4'd1, 4'd0, 4'd1, 4'd2};
      for (int k = 0; k < 5; k++) begin
         rd = {16'($urandom), $urandom, $urandom};
         send_frame(8'(order[k]), rd, 1'b0, 4'b0001 << order[k]);
         chk("all_cfg_not_with_wr_en", {127'd0, all_cfg}, 128'd0);
         @(negedge clk);
         chk("all_cfg_after_commit", {127'd0, all_cfg}, {127'd0, (k == 4)});
      end
      wait_idle();
      chk("all_cfg_stays", {127'd0, all_cfg}, 128'd1);

      // Reset mid-frame: the partial frame must never commit
      send_byte(8'h00, 1'b0);
      for (int k = 0; k < 5; k++) begin
         send_byte(8'h5A, 1'b0);
      end
      base = pulses;
      reset_dut();
      send_frame(8'h00, 80'h0A_09_08_07_06_05_04_03_02_01, 1'b0, 4'b0001);
      wait_idle();
      chk("midreset_one_pulse", 128'(pulses - base), 128'd1);
      chk("midreset_all_cfg_cleared", {127'd0, all_cfg}, 128'd0);

      chk("final_sb_empty", 128'(sb_q.size()), 128'd0);
      chk("final_pulse_count", 128'(pulses), 128'(pushes));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   // Hard time limit so the run always ends
   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
